// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer SRAM writer.
//   - FSM state encoding (plain localparam constants)
//   - px_t: one queued pixel write {x, y, data}, 34 bits
//   - mk_addr(): SRAM word address for a pixel, {x[8:0], y[8:0]}
package fb_pkg;

    localparam int COORD_W = 9;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 2 * COORD_W;            // 18-bit SRAM address
    localparam int PX_W    = 2 * COORD_W + DATA_W;   // 34-bit FIFO entry

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_W_SETUP = 3'd2;
    localparam logic [2:0] ST_W_PULSE = 3'd3;
    localparam logic [2:0] ST_W_HOLD  = 3'd4;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [DATA_W-1:0]  data;
    } px_t;

    function automatic logic [ADDR_W-1:0] mk_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/px_fifo.sv
// px_fifo: synchronous, count-based pixel-write FIFO.
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   push, push_px write one entry (caller guarantees !full)
//   pop           drop the head entry (ignored when empty)
//   head          entry at the read pointer
//   nxt           entry behind the head (valid when count >= 2); lets the
//                 writer load the following pixel on the same edge it pops
//   full, empty   occupancy flags
//   count         current occupancy, 0..FIFO_DEPTH
module px_fifo
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  px_t                             push_px,
    input  logic                            pop,
    output px_t                             head,
    output px_t                             nxt,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    px_t            mem [FIFO_DEPTH];
    logic [PW-1:0]  wp;
    logic [PW-1:0]  rp;
    logic [CW-1:0]  cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;

    // Power-of-two depth: pointers wrap by natural overflow.
    assign head = mem[rp];
    assign nxt  = mem[rp + PW'(1)];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= push_px;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop)  rp <= rp + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: arbitrates a 16-bit async SRAM between scanout reads and
// queued rasterizer pixel writes.
// Ports:
//   CLOCK_50, RESET            clock / synchronous active-high reset
//   wr_valid/wr_ready          pixel-write handshake, wr_x/wr_y/wr_data payload
//   rd_req, rd_x, rd_y         scanout read request for this cycle
//   rd_data, rd_valid          registered read word, valid one cycle after READ
//   idle                       FIFO empty and no write cycle in flight
//   SRAM_*                     SRAM pins; CE/UB/LB tied active
// Reads have priority only at decision points (IDLE/READ, end of W_HOLD);
// a started write always runs its full SETUP+PULSE+HOLD sequence.
// All SRAM control/address/OE outputs are registered from the next state,
// so they line up with the state they belong to and cannot glitch.
module fb_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [8:0]  wr_x,
    input  logic [8:0]  wr_y,
    input  logic [15:0] wr_data,
    input  logic        rd_req,
    input  logic [8:0]  rd_x,
    input  logic [8:0]  rd_y,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        idle,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N
);

    localparam int CNT_W = 8;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               start_wr;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    px_t                fifo_head;
    px_t                fifo_nxt;
    px_t                wr_px;
    px_t                start_px;

    logic               we_n_q;
    logic               oe_n_q;
    logic               dq_oe;
    logic [15:0]        dq_out;
    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        rd_data_q;
    // [0]: current cycle is READ, [1]: rd_data holds that read's word
    logic [1:0]         vld_pipe;

    assign wr_px    = '{x: wr_x, y: wr_y, data: wr_data};
    assign wr_ready = !fifo_full;
    assign push     = wr_valid && !fifo_full;
    assign pop      = (state == ST_W_HOLD) && (cnt == '0);

    px_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (CLOCK_50),
        .rst     (RESET),
        .push    (push),
        .push_px (wr_px),
        .pop     (pop),
        .head    (fifo_head),
        .nxt     (fifo_nxt),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Back-to-back writes leave W_HOLD on the popping edge, when the head
    // is still the pixel just written; the next pixel sits one slot behind.
    assign start_px = pop ? fifo_nxt : fifo_head;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_wr  = 1'b0;
        case (state)
            ST_IDLE, ST_READ: begin
                if (rd_req) begin
                    state_nxt = ST_READ;
                end else if (!fifo_empty) begin
                    state_nxt = ST_W_SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                    start_wr  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_W_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_W_PULSE;
                    cnt_nxt   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_W_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = ST_W_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_W_HOLD: begin
                if (cnt == '0) begin
                    // Decide on occupancy after this edge's pop; a push
                    // landing on the same edge is picked up from IDLE.
                    if (rd_req) begin
                        state_nxt = ST_READ;
                    end else if (fifo_count > CW'(1)) begin
                        state_nxt = ST_W_SETUP;
                        cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                        start_wr  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            addr_q    <= '0;
            rd_data_q <= '0;
            vld_pipe  <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            we_n_q <= (state_nxt != ST_W_PULSE);
            oe_n_q <= (state_nxt != ST_READ);
            dq_oe  <= (state_nxt == ST_W_SETUP) || (state_nxt == ST_W_PULSE) ||
                      (state_nxt == ST_W_HOLD);
            // Address/data are loaded once per write and then held through
            // SETUP, PULSE and HOLD.
            if (state_nxt == ST_READ) begin
                addr_q <= mk_addr(rd_x, rd_y);
            end else if (start_wr) begin
                addr_q <= mk_addr(start_px.x, start_px.y);
                dq_out <= start_px.data;
            end
            vld_pipe[0] <= (state_nxt == ST_READ);
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) rd_data_q <= SRAM_DQ;
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign rd_data   = rd_data_q;
    assign rd_valid  = vld_pipe[1];
    assign idle      = fifo_empty && ((state == ST_IDLE) || (state == ST_READ));

endmodule

// File: tb/tb_fb_writer.sv
module tb_fb_writer;

    localparam int DEPTH = 8;
    localparam int SU    = 2;
    localparam int PU    = 4;
    localparam int HO    = 2;
    localparam int TOT   = SU + PU + HO;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic        wr_valid = 1'b0;
    logic [8:0]  wr_x     = '0;
    logic [8:0]  wr_y     = '0;
    logic [15:0] wr_data  = '0;
    logic        rd_req   = 1'b0;
    logic [8:0]  rd_x     = '0;
    logic [8:0]  rd_y     = '0;
    logic        wr_ready, rd_valid, idle;
    logic [15:0] rd_data;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N;

    fb_writer #(.FIFO_DEPTH(DEPTH), .SETUP_CYC(SU), .PULSE_CYC(PU), .HOLD_CYC(HO)) dut (
        .CLOCK_50 (CLOCK_50), .RESET (RESET),
        .wr_valid (wr_valid), .wr_ready (wr_ready),
        .wr_x (wr_x), .wr_y (wr_y), .wr_data (wr_data),
        .rd_req (rd_req), .rd_x (rd_x), .rd_y (rd_y),
        .rd_data (rd_data), .rd_valid (rd_valid), .idle (idle),
        .SRAM_ADDR (SRAM_ADDR), .SRAM_DQ (SRAM_DQ),
        .SRAM_WE_N (SRAM_WE_N), .SRAM_OE_N (SRAM_OE_N),
        .SRAM_UB_N (SRAM_UB_N), .SRAM_LB_N (SRAM_LB_N), .SRAM_CE_N (SRAM_CE_N)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // SRAM read model: fixed content per address, one planted word.
    function automatic logic [15:0] pat(input logic [17:0] a);
        return (a == 18'h00604) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
    endfunction

    assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? pat(SRAM_ADDR) : 16'bz;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of pending pixels {x,y,data}, cycles left in
    // the write in flight, and whether the bus is in a read cycle.
    logic [33:0] q[$];
    logic [33:0] cur;
    int          wr_left = 0;
    bit          m_read  = 0;
    logic [17:0] rd_addr_m = '0;
    logic [15:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from current inputs, advance, then compare.
    task automatic cycle(output bit acc);
        bit   exp_ready, decide, new_rdv;
        int   n, k;
        logic [33:0] pix;
        exp_ready = (q.size() < DEPTH);
        chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
        acc     = wr_valid && exp_ready;
        pix     = {wr_x, wr_y, wr_data};
        n       = q.size();
        new_rdv = m_read;
        if (new_rdv) exp_rdata = pat(rd_addr_m);
        m_read  = 0;
        decide  = 0;
        if (wr_left > 0) begin
            wr_left--;
            if (wr_left == 0) begin
                void'(q.pop_front());
                n--;
                decide = 1;
            end
        end else begin
            decide = 1;
        end
        if (decide) begin
            if (rd_req) begin
                m_read    = 1;
                rd_addr_m = {rd_x, rd_y};
            end else if (n > 0) begin
                wr_left = TOT;
                cur     = q[0];
            end
        end
        if (acc) q.push_back(pix);

        @(posedge CLOCK_50);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(new_rdv));
        if (new_rdv) chk("rd_data", 32'(rd_data), 32'(exp_rdata));
        if (wr_left > 0) begin
            k = TOT - wr_left + 1;
            chk("wr_we_n", 32'(SRAM_WE_N), 32'(!(k > SU && k <= SU + PU)));
            chk("wr_oe_n", 32'(SRAM_OE_N), 32'd1);
            chk("wr_addr", 32'(SRAM_ADDR), 32'(cur[33:16]));
            chk("wr_dq",   32'(SRAM_DQ),   32'(cur[15:0]));
        end else if (m_read) begin
            chk("rd_we_n", 32'(SRAM_WE_N), 32'd1);
            chk("rd_oe_n", 32'(SRAM_OE_N), 32'd0);
            chk("rd_addr", 32'(SRAM_ADDR), 32'(rd_addr_m));
        end else begin
            chk("id_we_n", 32'(SRAM_WE_N), 32'd1);
            chk("id_oe_n", 32'(SRAM_OE_N), 32'd1);
        end
        chk("idle", 32'(idle), 32'(q.size() == 0 && wr_left == 0));
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        q.delete();
        wr_left = 0;
        m_read  = 0;
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        chk("rst_we_n",  32'(SRAM_WE_N), 32'd1);
        chk("rst_oe_n",  32'(SRAM_OE_N), 32'd1);
        chk("rst_addr",  32'(SRAM_ADDR), 32'd0);
        chk("rst_rdata", 32'(rd_data),   32'd0);
        chk("rst_rvld",  32'(rd_valid),  32'd0);
        chk("rst_ready", 32'(wr_ready),  32'd1);
        chk("rst_idle",  32'(idle),      32'd1);
        chk("rst_ties",  32'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'd0);
    endtask

    task automatic rand_px();
        wr_x    = 9'($urandom);
        wr_y    = 9'($urandom);
        wr_data = 16'($urandom);
    endtask

    initial begin
        bit acc;
        int tries;

        do_reset();

        // Single write at x=5, y=7.
        wr_valid = 1; wr_x = 9'd5; wr_y = 9'd7; wr_data = 16'h0001;
        cycle(acc);
        chk("one_acc", 32'(acc), 32'd1);
        wr_valid = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(acc);
            if (i == 2) chk("one_setup_we", 32'(SRAM_WE_N), 32'd1);
            if (i == 3) begin
                chk("one_we_low", 32'(SRAM_WE_N), 32'd0);
                chk("one_addr",   32'(SRAM_ADDR), 32'h00A07);
                chk("one_dq",     32'(SRAM_DQ),   32'h0001);
            end
            if (i == 6) chk("one_we_low6", 32'(SRAM_WE_N), 32'd0);
            if (i == 7) chk("one_we_hi7",  32'(SRAM_WE_N), 32'd1);
            if (i == 8) chk("one_busy8",   32'(idle),      32'd0);
            if (i == 9) chk("one_idle9",   32'(idle),      32'd1);
        end

        // Nine back-to-back pushes; each request held until accepted.
        for (int p = 0; p < 9; p++) begin
            wr_valid = 1; rand_px();
            tries = 0;
            do begin
                cycle(acc);
                tries++;
            end while (!acc && tries < 100);
            if (!acc) chk("nine_timeout", 32'(tries), 32'd0);
            if (p == 7) chk("nine_full", 32'(wr_ready), 32'd0);
        end
        wr_valid = 0;
        for (int i = 0; i < 9 * TOT + 4; i++) cycle(acc);

        // Scanout read of (3,4).
        rd_req = 1; rd_x = 9'd3; rd_y = 9'd4;
        cycle(acc);
        rd_req = 0;
        chk("rd_addr604", 32'(SRAM_ADDR), 32'h00604);
        chk("rd_oe_low",  32'(SRAM_OE_N), 32'd0);
        cycle(acc);
        chk("rd_vld1",  32'(rd_valid), 32'd1);
        chk("rd_beef",  32'(rd_data),  32'hBEEF);
        cycle(acc);
        chk("rd_vld0",  32'(rd_valid), 32'd0);

        // rd_req arriving mid-pulse must not cut the write short.
        wr_valid = 1; rand_px();
        cycle(acc);
        wr_valid = 0;
        for (int i = 0; i < 4; i++) cycle(acc);
        rd_req = 1; rd_x = 9'($urandom); rd_y = 9'($urandom);
        for (int i = 0; i < 8; i++) cycle(acc);
        rd_req = 0;
        for (int i = 0; i < 4; i++) cycle(acc);

        // Reset during W_PULSE with three more entries queued.
        for (int p = 0; p < 4; p++) begin
            wr_valid = 1; rand_px();
            cycle(acc);
        end
        wr_valid = 0;
        cycle(acc);
        chk("pre_rst_pulse", 32'(SRAM_WE_N), 32'd0);
        do_reset();
        for (int i = 0; i < 3 * TOT; i++) begin
            cycle(acc);
            chk("post_rst_we", 32'(SRAM_WE_N), 32'd1);
        end

        // Hold wr_valid high long enough to hit full with a pop pending.
        wr_valid = 1;
        for (int i = 0; i < 40; i++) begin
            if (wr_left == 1 && q.size() == DEPTH)
                chk("full_pop_ready", 32'(wr_ready), 32'd0);
            rand_px();
            cycle(acc);
        end
        wr_valid = 0;
        for (int i = 0; i < (DEPTH + 2) * TOT; i++) cycle(acc);

        // Random traffic with varying read/write densities.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 250; i++) begin
                wr_valid = ($urandom_range(0, 3) < ph + 1);
                rd_req   = ($urandom_range(0, 7) < 2 * ph);
                rd_x     = 9'($urandom);
                rd_y     = 9'($urandom);
                rand_px();
                cycle(acc);
            end
        end
        wr_valid = 0; rd_req = 0;
        for (int i = 0; i < (DEPTH + 2) * TOT; i++) cycle(acc);
        chk("final_idle", 32'(idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
